nes_cpu_bus_resp: RTL
=====================

NES_CPU_BUS_RESP -- requirements
Module: nes_cpu_bus_resp

Interface
REQ-001 SHALL have parameter RAM_AW, default 11, internal RAM address width (2 KiB).
REQ-002 SHALL have parameter RESET_VEC, default 16'h8000, value returned at $FFFC/$FFFD (lo/hi).
REQ-003 SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port cpu_addr  in  16  CPU address bus.
REQ-006 SHALL have port cpu_rw  in  1  1=read, 0=write.
REQ-007 SHALL have port cpu_dout  in  8  CPU write data.
REQ-008 SHALL have port cpu_din  out  8  registered read data to CPU.
REQ-009 SHALL have port cpu_rdy  out  1  0 stalls CPU (OAM DMA).
REQ-010 SHALL have port ppu_cs  out  1  one-cycle PPU register access strobe.
REQ-011 SHALL have port ppu_rw  out  1  PPU access direction, 1=read.
REQ-012 SHALL have port ppu_reg  out  3  PPU register index (addr[2:0]).
REQ-013 SHALL have port ppu_wdata  out  8  PPU write data.
REQ-014 SHALL have port ppu_rdata  in  8  PPU read data, valid same cycle as ppu_cs.

Function
REQ-015 SHALL decode $0000-$1FFF to internal RAM, mirrored with addr[RAM_AW-1:0].
REQ-016 SHALL decode $2000-$3FFF to PPU: ppu_cs=1, ppu_reg=addr[2:0], ppu_rw=cpu_rw, ppu_wdata=cpu_dout, combinationally in the access cycle.
REQ-017 SHALL decode $4014 write as OAM DMA start with page=cpu_dout.
REQ-018 SHALL decode $FFFC/$FFFD reads to RESET_VEC[7:0]/RESET_VEC[15:8].
REQ-019 SHALL treat all other addresses as open bus: reads return the last value driven on the data bus (read or write); writes ignored.
REQ-020 SHALL register every read result into cpu_din at the rising edge ending the access cycle (one-cycle read latency); cpu_din holds until the next read.
REQ-021 SHALL write RAM at the rising edge ending a write cycle; a read of the same address in the next cycle returns the new value.
REQ-022 SHALL maintain a parity flag toggling every cycle from reset (0 in the first cycle after reset release).
REQ-023 SHALL run a DMA FSM with states IDLE, DUMMY, ALIGN, RD, WR.
REQ-024 IDLE->DUMMY on $4014 write; cpu_rdy SHALL be 0 from the next cycle until DMA returns to IDLE.
REQ-025 DUMMY->ALIGN if parity=1 in DUMMY, else DUMMY->RD; ALIGN->RD.
REQ-026 RD SHALL read source address {page, idx} through the REQ-015/019 decode (PPU range and $4014 read as open bus); RD->WR.
REQ-027 WR SHALL drive ppu_cs=1, ppu_rw=0, ppu_reg=3'd4, ppu_wdata=byte read in RD; idx increments; WR->RD if idx!=255, else WR->IDLE.
REQ-028 Total stall SHALL be 513 cycles (parity even at DUMMY) or 514 cycles (odd).
REQ-029 idx SHALL be 8 bits and reset to 0 at each DMA start; no wrap beyond 256 transfers.
REQ-030 SHALL ignore CPU bus inputs while the FSM is not IDLE (no RAM write, no PPU strobe, no nested DMA).
REQ-031 Open-bus value SHALL update with every DMA read byte.

Reset
REQ-032 On rst=1, SHALL immediately force: FSM=IDLE, cpu_rdy=1, cpu_din=8'h00, ppu_cs=0, ppu_rw=1, ppu_reg=0, ppu_wdata=0, idx=0, parity=0, open bus=8'h00.
REQ-033 rst asserted mid-DMA SHALL abort the transfer; cpu_rdy=1 in the same cycle; no further PPU writes.
REQ-034 RAM contents SHALL not be cleared by reset.

Verification
REQ-035 Write $0005=8'hA5, read $1805 -> cpu_din=8'hA5 one cycle after read.
REQ-036 Read $2002 with ppu_rdata=8'h80 -> ppu_cs=1, ppu_reg=2, ppu_rw=1; cpu_din=8'h80; then read $5000 -> cpu_din=8'h80 (open bus).
REQ-037 Read $FFFC/$FFFD -> 8'h00 then 8'h80 with default RESET_VEC.
REQ-038 Fill RAM $0200-$02FF with i, write $4014=8'h02 on even parity -> cpu_rdy low exactly 513 cycles; 256 ppu_cs writes to reg 4 with data 0..255 in order.
REQ-039 Same DMA started on odd parity -> cpu_rdy low exactly 514 cycles, identical data sequence.
REQ-040 Assert rst after 10 DMA writes -> cpu_rdy=1 and ppu_cs=0 immediately; no ppu_cs after release; prior RAM contents intact.

Source files
------------

// File: rtl/nes_cpu_bus_resp.sv
// NES CPU bus responder: 2 KiB mirrored RAM, PPU register strobes, reset vector,
// open-bus reads and the $4014 OAM DMA engine that stalls the CPU while it copies a page.
module nes_cpu_bus_resp #(
  parameter int          RAM_AW    = 11,
  parameter logic [15:0] RESET_VEC = 16'h8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  output logic        ppu_cs,
  output logic        ppu_rw,
  output logic [2:0]  ppu_reg,
  output logic [7:0]  ppu_wdata,
  input  logic [7:0]  ppu_rdata
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  typedef enum logic [2:0] {IDLE, DUMMY, ALIGN, RD, WR} dma_state_t;

  dma_state_t  state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  dma_byte;
  logic [7:0]  open_bus;
  logic        parity;
  logic [7:0]  ram [0:RAM_DEPTH-1];

  logic        cpu_active;
  logic [15:0] rd_addr;
  logic [7:0]  ram_q;
  logic [7:0]  read_val;

  assign cpu_active = (state == IDLE);
  assign cpu_rdy    = cpu_active;

  // One shared read path: the DMA engine borrows it in RD, where the PPU window reads as open bus.
  assign rd_addr = (state == RD) ? {page, idx} : cpu_addr;
  assign ram_q   = ram[rd_addr[RAM_AW-1:0]];

  always_comb begin
    read_val = open_bus;
    if (rd_addr[15:13] == 3'b000)
      read_val = ram_q;
    else if (rd_addr[15:13] == 3'b001 && state != RD)
      read_val = ppu_rdata;
    else if (rd_addr == 16'hFFFC)
      read_val = RESET_VEC[7:0];
    else if (rd_addr == 16'hFFFD)
      read_val = RESET_VEC[15:8];
  end

  always_comb begin
    ppu_cs    = 1'b0;
    ppu_rw    = 1'b1;
    ppu_reg   = 3'd0;
    ppu_wdata = 8'h00;
    if (!rst) begin
      if (state == WR) begin
        ppu_cs    = 1'b1;
        ppu_rw    = 1'b0;
        ppu_reg   = 3'd4;
        ppu_wdata = dma_byte;
      end else if (cpu_active && cpu_addr[15:13] == 3'b001) begin
        ppu_cs    = 1'b1;
        ppu_rw    = cpu_rw;
        ppu_reg   = cpu_addr[2:0];
        ppu_wdata = cpu_dout;
      end
    end
  end

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (!rst && cpu_active && !cpu_rw && cpu_addr[15:13] == 3'b000)
      ram[cpu_addr[RAM_AW-1:0]] <= cpu_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      page     <= 8'h00;
      idx      <= 8'h00;
      dma_byte <= 8'h00;
      open_bus <= 8'h00;
      parity   <= 1'b0;
      cpu_din  <= 8'h00;
    end else begin
      parity <= ~parity;
      case (state)
        IDLE: begin
          if (!cpu_rw) begin
            open_bus <= cpu_dout;
            if (cpu_addr == 16'h4014) begin
              state <= DUMMY;
              page  <= cpu_dout;
              idx   <= 8'h00;
            end
          end else begin
            cpu_din  <= read_val;
            open_bus <= read_val;
          end
        end
        DUMMY: state <= parity ? ALIGN : RD;
        ALIGN: state <= RD;
        RD: begin
          dma_byte <= read_val;
          open_bus <= read_val;
          state    <= WR;
        end
        WR: begin
          idx   <= idx + 8'd1;
          state <= (idx == 8'hFF) ? IDLE : RD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
